// File: rtl/fp_pkg.sv
// Shared defaults and types for the forward-propagation datapath and its
// weight ROM arbiter.
package fp_pkg;
  localparam int DEF_N_REQ    = 4;
  localparam int DEF_AW       = 15;
  localparam int DEF_DW       = 32;
  localparam int DEF_LOCK_MAX = 16;

  typedef logic [$clog2(DEF_N_REQ)-1:0] req_id_t;
endpackage

// File: rtl/weight_rom_arbiter_if.sv
// Engine-side bundle: requests/addresses in, grants and read returns out.
interface weight_rom_arbiter_if #(
  parameter int N_REQ = fp_pkg::DEF_N_REQ,
  parameter int AW    = fp_pkg::DEF_AW,
  parameter int DW    = fp_pkg::DEF_DW
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         lock;
  logic [N_REQ-1:0][AW-1:0] addr;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rvalid;
  logic [DW-1:0]            rdata;

  modport master (output req, lock, addr, input gnt, rvalid, rdata);
  modport slave  (input req, lock, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/weight_rom_arbiter_rr_pick.sv
// Rotating priority encoder: first requester at or after start_i wins.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] start_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o,
  output logic           any_o
);
  always_comb begin
    int idx;
    idx   = 0;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/weight_rom_arbiter.sv
// Round-robin weight ROM arbiter with burst lock and fixed-latency return
// routing back to the granted engine.
module weight_rom_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int ROM_LAT  = 1,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  weight_rom_arbiter_if.slave  eng,
  output logic                 rom_rd_en_o,
  output logic [AW-1:0]        rom_addr_o,
  input  logic [DW-1:0]        rom_rdata_i,
  output logic                 busy_o
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(LOCK_MAX + 1);

  logic [IDW-1:0] last_q, last_d, start, rr_id, win_id;
  logic           lk_vld_q, lk_vld_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0] rr_gnt, gnt;
  logic           rr_any, any, force_lk;

  logic [ROM_LAT-1:0]          vld_pipe_q;
  logic [ROM_LAT-1:0][IDW-1:0] id_pipe_q;
  logic [ROM_LAT:0]            vld_sh;
  logic [ROM_LAT:0][IDW-1:0]   id_sh;

  assign start = (last_q == IDW'(N_REQ - 1)) ? '0 : last_q + 1'b1;

  rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
    .req_i   (eng.req),
    .start_i (start),
    .gnt_o   (rr_gnt),
    .id_o    (rr_id),
    .any_o   (rr_any)
  );

  // A locked holder keeps the ROM only while it still requests and the
  // burst cap has not been reached; otherwise plain round-robin applies.
  always_comb begin
    force_lk = lk_vld_q && eng.req[last_q] && (cnt_q < CW'(LOCK_MAX));
    gnt      = '0;
    win_id   = rr_id;
    any      = 1'b0;
    last_d   = last_q;
    cnt_d    = cnt_q;
    lk_vld_d = lk_vld_q;
    if (rst_ni) begin
      if (force_lk) begin
        gnt[last_q] = 1'b1;
        win_id      = last_q;
        any         = 1'b1;
      end else begin
        gnt = rr_gnt;
        any = rr_any;
      end
    end
    if (any) begin
      last_d   = win_id;
      cnt_d    = force_lk ? cnt_q + 1'b1 : '0;
      lk_vld_d = eng.lock[win_id];
    end else if (lk_vld_q) begin
      cnt_d    = '0;
      lk_vld_d = 1'b0;
    end
  end

  assign eng.gnt     = gnt;
  assign rom_rd_en_o = any;
  assign rom_addr_o  = any ? eng.addr[win_id] : '0;

  assign vld_sh = {vld_pipe_q, any};
  assign id_sh  = {id_pipe_q, win_id};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q     <= IDW'(N_REQ - 1);
      lk_vld_q   <= 1'b0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      last_q     <= last_d;
      lk_vld_q   <= lk_vld_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_sh[ROM_LAT-1:0];
      id_pipe_q  <= id_sh[ROM_LAT-1:0];
    end
  end

  // Returns are masked during reset so a discarded read never surfaces.
  always_comb begin
    eng.rvalid = '0;
    if (rst_ni && vld_pipe_q[ROM_LAT-1]) eng.rvalid[id_pipe_q[ROM_LAT-1]] = 1'b1;
  end

  assign eng.rdata = rom_rdata_i;
  assign busy_o    = rst_ni && (any || (|vld_pipe_q));
endmodule

// File: doc/weight_rom_arbiter.md
WEIGHT_ROM_ARBITER -- requirements
Module: weight_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of layer engines sharing the weight ROM.
REQ-002 Parameter AW, default 15, weight ROM address width.
REQ-003 Parameter DW, default 32, weight word width.
REQ-004 Parameter ROM_LAT, default 1, fixed ROM read latency in cycles, legal 1..2.
REQ-005 Parameter LOCK_MAX, default 16, maximum consecutive locked grants.
REQ-006 Clk  in  1  sole clock, all state on rising edge.
REQ-007 Reset  in  1  synchronous, active-low; Reset=0 at a rising edge resets.
REQ-008 req  in  N_REQ  per-engine read request, held until granted.
REQ-009 lock  in  N_REQ  per-engine burst hint: keep grant on next cycle.
REQ-010 addr  in  N_REQ x AW  per-engine weight address, stable while req high.
REQ-011 gnt  out  N_REQ  one-hot or zero, combinational; request accepted this cycle.
REQ-012 rom_rd_en  out  1  ROM read strobe.
REQ-013 rom_addr  out  AW  ROM address; addr of granted engine, 0 when idle.
REQ-014 rom_rdata  in  DW  ROM data, valid ROM_LAT cycles after rom_rd_en.
REQ-015 rvalid  out  N_REQ  one-hot or zero; rdata belongs to that engine.
REQ-016 rdata  out  DW  rom_rdata passed through unregistered.
REQ-017 busy  out  1  any grant this cycle or any read in flight.

Function
REQ-018 At most one gnt bit SHALL be high per cycle; gnt[i] only if req[i]=1.
REQ-019 rom_rd_en SHALL equal OR of gnt; rom_addr SHALL equal addr of granted engine.
REQ-020 Round-robin: search order starts at (last_winner+1) mod N_REQ; last_winner updates on every grant.
REQ-021 Lock: if winner had lock=1 when granted and still has req=1 next cycle, it SHALL win again regardless of others.
REQ-022 lock_cnt counts consecutive locked grants; on reaching LOCK_MAX, next cycle SHALL use normal round-robin and lock_cnt clears.
REQ-023 lock_cnt SHALL clear when the lock holder drops req or lock, or another engine wins.
REQ-024 In-flight tracking: ROM_LAT-deep shift of {valid, winner id}; rvalid[id]=1 exactly ROM_LAT cycles after grant.
REQ-025 Back-to-back grants SHALL sustain one read per cycle; no bubble between grants.
REQ-026 No req: gnt=0, rom_rd_en=0, rom_addr=0; last_winner and lock_cnt unchanged.
REQ-027 Simultaneous new request and return of data to same engine SHALL both occur in one cycle.
REQ-028 Engine SHALL NOT be required to drop req after grant; continuous req yields a grant every N_REQ cycles under full contention, unlocked.

Reset
REQ-029 While Reset=0: gnt=0, rom_rd_en=0, rom_addr=0 combinationally.
REQ-030 After reset: last_winner=N_REQ-1 (engine 0 highest priority), lock_cnt=0, in-flight pipe empty, rvalid=0, busy=0.
REQ-031 Reset mid-operation SHALL discard in-flight reads; no rvalid for them after reset.

Structure
REQ-032 Package fp_pkg SHALL hold N_REQ, AW, DW, LOCK_MAX defaults and typedef req_id_t (clog2 N_REQ bits), shared with forward_propagation.
REQ-033 One sub-module rr_pick: combinational rotating priority encoder (req, start index -> one-hot grant, id, any).

Verification
REQ-034 After reset, req=4'b1111 held, lock=0 -> gnt sequence 0001,0010,0100,1000,0001; rvalid same sequence delayed ROM_LAT.
REQ-035 req[2]=1 alone, addr[2]=0x1234 -> same cycle gnt=0100, rom_addr=0x1234; ROM_LAT later rvalid=0100, rdata=ROM[0x1234].
REQ-036 req=1111, lock[1]=1 constant, LOCK_MAX=16 -> engine 1 wins 16 grants after first win, then gnt=0100 next.
REQ-037 Reset=0 one cycle with a read in flight -> rvalid stays 0000, busy=0 next cycle, first grant then goes to engine 0.
REQ-038 req=0 for 5 cycles between bursts -> rom_rd_en=0, rom_addr=0; resumes at last_winner+1.
